key_debounce_encoder: RTL and testbench

- Front-end stage directly upstream of the piano Controller.
- Synchronises and debounces the 7 raw piano key switches, then produces clean stable key levels.
- Priority-encodes the pressed key into a 4-bit note code and emits single-cycle press/release events.
- The Controller consumes these outputs instead of raw switches, so free, auto and learn modes all see glitch-free notes.

---
 rtl/key_debounce_encoder.sv | 125 ++++++++++++
 tb/tb_key_debounce_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_encoder.sv
// rtl/key_debounce_encoder.sv - debounced 7-key piano front end with priority note encoder and press/release events
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_encoder #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 21,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_stable,
  output logic [3:0]          note_code,
  output logic                note_valid,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic                long_press
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (NUM_KEYS != 7 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) || LONG_CYCLES < 1) begin : g_param_check
    $error("key_debounce_encoder: unsupported parameter set");
  end

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  logic [NUM_KEYS-1:0] keys_meta;
  logic [NUM_KEYS-1:0] keys_sync;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  logic [3:0]          code_nxt;
  state_t              state;
  state_t              state_nxt;
  logic                press_nxt;
  logic                release_nxt;

  // Two-flop synchroniser followed by per-key stability counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_meta   <= '0;
      keys_sync   <= '0;
      keys_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      keys_meta <= keys_raw;
      keys_sync <= keys_meta;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (keys_sync[i] == keys_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          keys_stable[i] <= ~keys_stable[i];
          db_cnt[i]      <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-numbered pressed key wins.
  always_comb begin
    code_nxt = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_stable[i]) code_nxt = 4'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (code_nxt != 4'd0) state_nxt = HELD;
      HELD:    if (code_nxt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new nonzero code is a press even while held (legato).
  always_comb begin
    press_nxt   = (code_nxt != 4'd0) && ((state == IDLE) || (code_nxt != note_code));
    release_nxt = (state == HELD) && (code_nxt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_code     <= 4'd0;
      note_valid    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      note_code     <= code_nxt;
      note_valid    <= (code_nxt != 4'd0);
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = ($clog2(LONG_CYCLES) > CNT_W) ? $clog2(LONG_CYCLES) : CNT_W;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt;
  logic              long_keep;

  assign long_keep = (state == HELD) && (state_nxt == HELD) && (code_nxt == note_code);

  // Saturating hold timer; long_press is sticky until the held note ends or changes.
  always_ff @(posedge clk) begin
    if (reset || !long_keep) begin
      long_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      if (long_cnt != '1)        long_cnt   <= long_cnt + 1'b1;
      if (long_cnt == LONG_LAST) long_press <= 1'b1;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_encoder.sv
// tb/tb_key_debounce_encoder.sv - directed and randomized check of key_debounce_encoder against a behavioural model
module tb_key_debounce_encoder;

  localparam int DB   = 4;
  localparam int LONG = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] keys_raw;
  logic [6:0] keys_stable;
  logic [3:0] note_code;
  logic       note_valid;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;

  int vectors = 0;
  int miscompares = 0;
  int press_seen = 0;
  int rel_seen = 0;

  key_debounce_encoder #(
    .NUM_KEYS(7), .DEBOUNCE_CYCLES(DB), .CNT_W(4), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .reset(reset), .keys_raw(keys_raw), .keys_stable(keys_stable),
    .note_code(note_code), .note_valid(note_valid), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Model: sync pipeline as two delayed copies; a key flips after DB consecutive disagreeing cycles.
  logic [6:0] m_s1, m_sync, m_stable;
  int         m_run [7];
  logic [3:0] m_note;
  logic       m_press, m_rel, m_long;
  int         m_held;

  function automatic logic [3:0] lowest_key(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  task automatic model_edge();
    logic [3:0] nn;
    if (reset) begin
      m_s1 = '0; m_sync = '0; m_stable = '0; m_note = '0;
      m_press = 0; m_rel = 0; m_long = 0; m_held = 0;
      for (int i = 0; i < 7; i++) m_run[i] = 0;
    end else begin
      nn = lowest_key(m_stable);
      m_press = (nn != 0) && (nn != m_note);
      m_rel   = (m_note != 0) && (nn == 0);
      m_held  = (nn != 0 && nn == m_note) ? m_held + 1 : 0;
`ifdef KEY_LONG_PRESS_EN
      m_long  = (nn != 0) && (m_held >= LONG);
`else
      m_long  = 1'b0;
`endif
      m_note = nn;
      for (int i = 0; i < 7; i++) begin
        if (m_sync[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_stable[i] = ~m_stable[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sync = m_s1;
      m_s1 = keys_raw;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("keys_stable", 32'(keys_stable), 32'(m_stable));
    chk("note_code", 32'(note_code), 32'(m_note));
    chk("note_valid", 32'(note_valid), 32'(m_note != 0));
    chk("press_pulse", 32'(press_pulse), 32'(m_press));
    chk("release_pulse", 32'(release_pulse), 32'(m_rel));
    chk("long_press", 32'(long_press), 32'(m_long));
    chk("pulse_excl", 32'(press_pulse & release_pulse), 32'd0);
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) rel_seen++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int st_edge, nt_edge, p0, r0, l_edge;
    reset = 1'b1;
    keys_raw = '0;
    for (int i = 0; i < 7; i++) m_run[i] = 0;
    m_held = 0;
    run(2);
    chk("reset_note", 32'(note_code), 32'd0);

    // First press: stable at edge 6, note at edge 7.
    reset = 1'b0;
    keys_raw = 7'b0000001;
    st_edge = -1; nt_edge = -1; p0 = press_seen;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (st_edge < 0 && keys_stable[0] === 1'b1) st_edge = k;
      if (nt_edge < 0 && note_code === 4'd1) nt_edge = k;
    end
    chk("first_stable_edge", 32'(st_edge), 32'd6);
    chk("first_note_edge", 32'(nt_edge), 32'd7);
    chk("first_press_count", 32'(press_seen - p0), 32'd1);

    keys_raw = '0;
    run(12);

    // Three-cycle bounce is rejected.
    p0 = press_seen; r0 = rel_seen;
    keys_raw = 7'b0000100;
    run(3);
    keys_raw = '0;
    run(12);
    chk("bounce_stable", 32'(keys_stable), 32'd0);
    chk("bounce_pulses", 32'((press_seen - p0) + (rel_seen - r0)), 32'd0);

    // Legato: key3 then add key1, then drop key1.
    keys_raw = 7'b0001000;
    run(12);
    chk("key3_note", 32'(note_code), 32'd4);
    p0 = press_seen; r0 = rel_seen;
    keys_raw = 7'b0001010;
    run(12);
    chk("legato_note", 32'(note_code), 32'd2);
    chk("legato_press", 32'(press_seen - p0), 32'd1);
    chk("legato_release", 32'(rel_seen - r0), 32'd0);
    p0 = press_seen;
    keys_raw = 7'b0001000;
    run(12);
    chk("back_note", 32'(note_code), 32'd4);
    chk("back_press", 32'(press_seen - p0), 32'd1);

    // Release from note 5: note 0 appears DB+3 edges after the raw change.
    keys_raw = 7'b0010000;
    run(12);
    chk("key4_note", 32'(note_code), 32'd5);
    r0 = rel_seen;
    keys_raw = '0;
    nt_edge = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (nt_edge < 0 && note_code === 4'd0) nt_edge = k;
    end
    chk("release_edge", 32'(nt_edge), 32'(DB + 3));
    chk("release_count", 32'(rel_seen - r0), 32'd1);

    // Reset mid-hold re-debounces the still-held key.
    keys_raw = 7'b0000001;
    run(12);
    reset = 1'b1;
    step();
    chk("midreset_note", 32'(note_code), 32'd0);
    chk("midreset_stable", 32'(keys_stable), 32'd0);
    reset = 1'b0;
    p0 = press_seen;
    nt_edge = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (nt_edge < 0 && note_code === 4'd1) nt_edge = k;
    end
    chk("midreset_renote_edge", 32'(nt_edge), 32'd7);
    chk("midreset_press", 32'(press_seen - p0), 32'd1);

    // Long press on key6.
    keys_raw = '0;
    run(12);
    keys_raw = 7'b1000000;
    nt_edge = -1; l_edge = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (nt_edge < 0 && note_code === 4'd7) nt_edge = k;
      if (l_edge < 0 && long_press === 1'b1) l_edge = k;
    end
`ifdef KEY_LONG_PRESS_EN
    chk("long_delay", 32'(l_edge - nt_edge), 32'(LONG));
`else
    chk("long_absent", 32'(l_edge), 32'hFFFF_FFFF);
`endif
    keys_raw = '0;
    run(12);
    chk("long_after_release", 32'(long_press), 32'd0);

    // Randomized hold patterns with occasional reset.
    for (int n = 0; n < 300; n++) begin
      int hold;
      keys_raw = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 20) : $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        reset = ($urandom_range(0, 99) == 0);
        step();
      end
      reset = 1'b0;
    end
    keys_raw = '0;
    run(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
